// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the Data_Memory port arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

    localparam logic REQ_DCACHE = 1'b0;
    localparam logic REQ_AUX    = 1'b1;

    // Watchdog counter width; a disabled watchdog still keeps a 1-bit counter.
    function automatic int unsigned wdog_width(input int unsigned timeout_cyc);
        return (timeout_cyc == 0) ? 1 : $clog2(timeout_cyc + 1);
    endfunction

endpackage

// File: rtl/dmem_arb_rr_pick.sv
// Combinational round-robin pick between the two requesters.
module dmem_arb_rr_pick
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic       grant_valid,
    output logic       grant_idx
);

    // Single requester wins outright; on contention the one not served last wins.
    always_comb begin
        grant_valid = |req;
        grant_idx   = REQ_DCACHE;
        if (req == 2'b11) begin
            grant_idx = ~last_owner;
        end else if (req[1]) begin
            grant_idx = REQ_AUX;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the shared 256-bit Data_Memory port.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 256,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req0_enable_i,
    input  logic              req0_write_i,
    input  logic [ADDR_W-1:0] req0_addr_i,
    input  logic [DATA_W-1:0] req0_data_i,
    output logic              req0_ack_o,
    output logic [DATA_W-1:0] req0_data_o,
    input  logic              req1_enable_i,
    input  logic              req1_write_i,
    input  logic [ADDR_W-1:0] req1_addr_i,
    input  logic [DATA_W-1:0] req1_data_i,
    output logic              req1_ack_o,
    output logic [DATA_W-1:0] req1_data_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic              busy_o,
    output logic              owner_o,
    output logic              timeout_o
);

    localparam int unsigned WDOG_W = wdog_width(TIMEOUT_CYC);
    localparam logic [WDOG_W-1:0] WDOG_SAT  = WDOG_W'((TIMEOUT_CYC == 0) ? 1 : TIMEOUT_CYC);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

    arb_state_e        state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_owner_q, last_owner_d;
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              timeout_q, timeout_d;

    logic              grant_valid;
    logic              grant_idx;
    logic              own_en;
    logic              own_write;
    logic [ADDR_W-1:0] own_addr;
    logic [DATA_W-1:0] own_data;
    logic              wdog_hit;

    dmem_arb_rr_pick u_rr_pick (
        .req         ({req1_enable_i, req0_enable_i}),
        .last_owner  (last_owner_q),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // Select the granted requester's live request signals.
    always_comb begin
        own_en    = req0_enable_i;
        own_write = req0_write_i;
        own_addr  = req0_addr_i;
        own_data  = req0_data_i;
        if (owner_q == REQ_AUX) begin
            own_en    = req1_enable_i;
            own_write = req1_write_i;
            own_addr  = req1_addr_i;
            own_data  = req1_data_i;
        end
    end

    assign wdog_hit = (TIMEOUT_CYC != 0) && (wdog_q == WDOG_LAST);

    // Next-state, watchdog and memory/ack output decode.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        wdog_d       = wdog_q;
        timeout_d    = timeout_q;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        req0_ack_o   = 1'b0;
        req1_ack_o   = 1'b0;

        case (state_q)
            IDLE: begin
                wdog_d = '0;
                if (grant_valid) begin
                    owner_d = grant_idx;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                mem_enable_o = own_en;
                mem_write_o  = own_write;
                mem_addr_o   = own_addr;
                mem_data_o   = own_data;
                if (wdog_q != WDOG_SAT) begin
                    wdog_d = wdog_q + WDOG_W'(1);
                end
                // Ack takes priority over both abort and watchdog expiry.
                if (mem_ack_i) begin
                    req0_ack_o   = (owner_q == REQ_DCACHE);
                    req1_ack_o   = (owner_q == REQ_AUX);
                    last_owner_d = owner_q;
                    state_d      = RELEASE;
                end else begin
                    if (wdog_hit) begin
                        timeout_d = 1'b1;
                    end
                    if (!own_en || wdog_hit) begin
                        state_d = RELEASE;
                    end
                end
            end
            RELEASE: begin
                wdog_d  = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= IDLE;
            owner_q      <= REQ_DCACHE;
            last_owner_q <= REQ_AUX;
            wdog_q       <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            wdog_q       <= wdog_d;
            timeout_q    <= timeout_d;
        end
    end

    // Read data fans out to both requesters, forced low while reset is held.
    assign req0_data_o = rst_i ? mem_data_i : '0;
    assign req1_data_o = rst_i ? mem_data_i : '0;

    assign busy_o    = (state_q != IDLE);
    assign owner_o   = owner_q;
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized self-checking bench for dmem_arbiter with a transaction-level model.
module tb_dmem_arbiter;

    localparam int TMO = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         rq_en   [2];
    logic         rq_wr   [2];
    logic [31:0]  rq_addr [2];
    logic [255:0] rq_wd   [2];
    logic         mem_ack = 1'b0;
    logic [255:0] mem_rdata = '0;

    logic         ack0, ack1, m_en, m_wr, busy, owner, tmo;
    logic [31:0]  m_addr;
    logic [255:0] m_wd, rd0, rd1;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(256), .TIMEOUT_CYC(TMO)) dut (
        .clk_i(clk), .rst_i(rst_n),
        .req0_enable_i(rq_en[0]), .req0_write_i(rq_wr[0]), .req0_addr_i(rq_addr[0]),
        .req0_data_i(rq_wd[0]), .req0_ack_o(ack0), .req0_data_o(rd0),
        .req1_enable_i(rq_en[1]), .req1_write_i(rq_wr[1]), .req1_addr_i(rq_addr[1]),
        .req1_data_i(rq_wd[1]), .req1_ack_o(ack1), .req1_data_o(rd1),
        .mem_enable_o(m_en), .mem_write_o(m_wr), .mem_addr_o(m_addr), .mem_data_o(m_wd),
        .mem_ack_i(mem_ack), .mem_data_i(mem_rdata),
        .busy_o(busy), .owner_o(owner), .timeout_o(tmo)
    );

    always #5 clk = ~clk;

    int n_vectors = 0;
    int n_miscompares = 0;

    // Reference model: who holds the port, how long, and what happens next.
    int  m_holder = -1;
    bit  m_release = 0;
    int  m_age = 0;
    int  m_lat = 0;
    bit  m_last = 1;
    bit  m_owner = 0;
    bit  m_tmo = 0;

    // Stimulus knobs and requester bookkeeping.
    bit  pend [2] = '{0, 0};
    bit  rnd_mode = 0;
    bit  stray_all = 0;
    bit  fix_rdata = 0;
    logic [255:0] fixed_rdata = '0;
    int  lat_cfg = 1;

    // Directed observations.
    int  en_cycles = 0;
    int  wr_match = 0;
    int  ack_log[$];
    int  gaps[$];
    bit  gap_arm = 0;
    int  gap_cnt = 0;
    logic [255:0] ack_data = '0;
    logic [255:0] pattern;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic clear_obs();
        en_cycles = 0;
        wr_match = 0;
        ack_log.delete();
        gaps.delete();
        gap_arm = 0;
        gap_cnt = 0;
    endtask

    task automatic compare_cycle();
        logic e_en, e_wr, e_a0, e_a1, e_busy;
        logic [31:0] e_addr;
        logic [255:0] e_wd, e_rd;
        e_en = 0; e_wr = 0; e_a0 = 0; e_a1 = 0; e_busy = 0; e_addr = '0; e_wd = '0;
        e_rd = rst_n ? mem_rdata : '0;
        if (rst_n) begin
            if (m_holder >= 0) begin
                e_en   = rq_en[m_holder];
                e_wr   = rq_wr[m_holder];
                e_addr = rq_addr[m_holder];
                e_wd   = rq_wd[m_holder];
                e_a0   = mem_ack && (m_holder == 0);
                e_a1   = mem_ack && (m_holder == 1);
                e_busy = 1;
            end else begin
                e_busy = m_release;
            end
        end
        check_eq("mem_enable", 256'(m_en), 256'(e_en));
        check_eq("mem_write", 256'(m_wr), 256'(e_wr));
        check_eq("mem_addr", 256'(m_addr), 256'(e_addr));
        check_eq("mem_data", m_wd, e_wd);
        check_eq("ack0", 256'(ack0), 256'(e_a0));
        check_eq("ack1", 256'(ack1), 256'(e_a1));
        check_eq("busy", 256'(busy), 256'(e_busy));
        check_eq("owner", 256'(owner), rst_n ? 256'(m_owner) : '0);
        check_eq("timeout", 256'(tmo), rst_n ? 256'(m_tmo) : '0);
        check_eq("rdata0", rd0, e_rd);
        check_eq("rdata1", rd1, e_rd);
        if (m_en) en_cycles++;
        if (m_wr && m_addr == 32'h20 && m_wd == pattern) wr_match++;
        if (gap_arm) begin
            if (m_en) begin gaps.push_back(gap_cnt); gap_arm = 0; end
            else gap_cnt++;
        end
        if (ack0 || ack1) begin gap_arm = 1; gap_cnt = 0; end
        if (ack0) begin ack_log.push_back(0); ack_data = rd0; end
        if (ack1) ack_log.push_back(1);
    endtask

    task automatic end_txn();
        m_holder = -1;
        m_release = 1;
    endtask

    task automatic model_step();
        int  h;
        bit  hit;
        if (m_holder >= 0) begin
            h = m_holder;
            if (mem_ack) begin
                m_last = h[0];
                pend[h] = 0;
                end_txn();
            end else begin
                hit = (m_age == TMO - 1);
                if (hit) m_tmo = 1;
                if (!rq_en[h] || hit) end_txn();
                else m_age++;
            end
        end else if (m_release) begin
            m_release = 0;
        end else if (rq_en[0] || rq_en[1]) begin
            if (rq_en[0] && rq_en[1]) m_holder = m_last ? 0 : 1;
            else m_holder = rq_en[1] ? 1 : 0;
            m_owner = m_holder[0];
            m_age = 0;
            m_lat = (lat_cfg < 0) ? int'($urandom_range(1, 12)) : lat_cfg;
        end
    endtask

    task automatic drive_next();
        for (int i = 0; i < 2; i++) begin
            if (rnd_mode && !pend[i] && $urandom_range(0, 2) == 0) begin
                pend[i] = 1;
                rq_wr[i] = $urandom_range(0, 1) == 1;
                rq_addr[i] = $urandom;
                rq_wd[i] = rand256();
            end
            if (rnd_mode && m_holder == i && $urandom_range(0, 39) == 0) pend[i] = 0;
            if (rnd_mode && m_holder == i && $urandom_range(0, 3) == 0) rq_wd[i] = rand256();
            rq_en[i] = pend[i];
        end
        if (m_holder >= 0) mem_ack = (m_lat != 0) && (m_age == m_lat - 1);
        else mem_ack = stray_all || (rnd_mode && $urandom_range(0, 3) == 0);
        mem_rdata = fix_rdata ? fixed_rdata : rand256();
    endtask

    task automatic cycle();
        @(negedge clk);
        compare_cycle();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
        drive_next();
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_en"}, 256'(m_en), '0);
        check_eq({tag, "_wr"}, 256'(m_wr), '0);
        check_eq({tag, "_addr"}, 256'(m_addr), '0);
        check_eq({tag, "_data"}, m_wd, '0);
        check_eq({tag, "_acks"}, 256'({ack0, ack1}), '0);
        check_eq({tag, "_busy"}, 256'(busy), '0);
        check_eq({tag, "_owner"}, 256'(owner), '0);
        check_eq({tag, "_tmo"}, 256'(tmo), '0);
        check_eq({tag, "_rd"}, rd0 | rd1, '0);
    endtask

    task automatic reset_dut(input int hold);
        @(negedge clk);
        #2;
        rst_n = 0;
        m_holder = -1; m_release = 0; m_last = 1; m_owner = 0; m_tmo = 0; m_age = 0;
        #1;
        check_all_zero("rst");
        repeat (hold) cycle();
        rst_n = 1;
    endtask

    task automatic run_until_idle(input string tag, input int budget);
        int n = 0;
        while ((pend[0] || pend[1] || m_holder >= 0 || m_release) && n < budget) begin
            cycle();
            n++;
        end
        if (n >= budget) check_eq({tag, "_budget"}, 256'(n), '0);
    endtask

    task automatic start_req(input int i, input bit wr, input logic [31:0] a, input logic [255:0] d);
        pend[i] = 1; rq_en[i] = 1; rq_wr[i] = wr; rq_addr[i] = a; rq_wd[i] = d;
    endtask

    initial begin
        int n;
        pattern = {8{32'hDEADBEEF}};
        for (int i = 0; i < 2; i++) begin
            rq_en[i] = 0; rq_wr[i] = 0; rq_addr[i] = '0; rq_wd[i] = '0;
        end
        repeat (2) cycle();
        reset_dut(2);

        // Single read, ten GRANT cycles, data 0x5 returned.
        clear_obs();
        fix_rdata = 1; fixed_rdata = 256'h5; lat_cfg = 10;
        start_req(0, 0, 32'h400, '0);
        run_until_idle("t1", 100);
        fix_rdata = 0;
        check_eq("t1_en_cycles", 256'(en_cycles), 256'(10));
        check_eq("t1_acks", 256'(ack_log.size()), 256'(1));
        check_eq("t1_ack_data", ack_data, 256'h5);

        // Contention from reset: alternation 0,1,0,1 and two dead cycles.
        reset_dut(2);
        clear_obs();
        lat_cfg = 3;
        start_req(0, 0, 32'h100, '0);
        start_req(1, 0, 32'h200, '0);
        run_until_idle("t2a", 100);
        start_req(0, 0, 32'h140, '0);
        start_req(1, 0, 32'h240, '0);
        run_until_idle("t2b", 100);
        check_eq("t2_nacks", 256'(ack_log.size()), 256'(4));
        for (int i = 0; i < 4 && i < ack_log.size(); i++)
            check_eq("t2_order", 256'(ack_log[i]), 256'(i % 2));
        check_eq("t2_gap", 256'((gaps.size() > 0) ? gaps[0] : 99), 256'(2));

        // req1 write held for the whole grant while req0 waits.
        clear_obs();
        lat_cfg = 5;
        start_req(1, 1, 32'h20, pattern);
        cycle();
        start_req(0, 0, 32'h80, '0);
        run_until_idle("t3", 100);
        check_eq("t3_wr_cycles", 256'(wr_match), 256'(5));
        check_eq("t3_nacks", 256'(ack_log.size()), 256'(2));
        if (ack_log.size() == 2) begin
            check_eq("t3_first", 256'(ack_log[0]), 256'(1));
            check_eq("t3_second", 256'(ack_log[1]), 256'(0));
        end

        // Stray acks outside GRANT are dropped.
        clear_obs();
        stray_all = 1; lat_cfg = 3;
        repeat (3) cycle();
        start_req(0, 0, 32'h44, '0);
        run_until_idle("t6", 100);
        repeat (3) cycle();
        stray_all = 0;
        check_eq("t6_nacks", 256'(ack_log.size()), 256'(1));

        // Randomized traffic with aborts and stray acks.
        rnd_mode = 1; lat_cfg = -1;
        repeat (3000) cycle();
        rnd_mode = 0;
        run_until_idle("rnd", 200);

        // Watchdog: memory never answers.
        clear_obs();
        lat_cfg = 0;
        start_req(0, 0, 32'h600, '0);
        n = 0;
        while (!m_tmo && n < 40) begin cycle(); n++; end
        check_eq("t4_fired", 256'(m_tmo), 256'(1));
        pend[0] = 0; rq_en[0] = 0;
        repeat (10) cycle();
        check_eq("t4_en_cycles", 256'(en_cycles), 256'(16));
        check_eq("t4_nacks", 256'(ack_log.size()), 256'(0));
        check_eq("t4_sticky", 256'(tmo), 256'(1));

        // Reset mid-GRANT, then req0 wins the first contention.
        clear_obs();
        start_req(0, 0, 32'h700, '0);
        start_req(1, 0, 32'h780, '0);
        repeat (5) cycle();
        check_eq("t5_granted", 256'(m_en), 256'(1));
        lat_cfg = 4;
        reset_dut(3);
        clear_obs();
        run_until_idle("t5", 100);
        check_eq("t5_nacks", 256'(ack_log.size()), 256'(2));
        check_eq("t5_first", 256'((ack_log.size() > 0) ? ack_log[0] : 9), 256'(0));
        check_eq("t5_tmo_clr", 256'(tmo), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
